// File: rtl/fracdiv_pkg.sv
// Shared defaults, increment constants and helpers for the fractional clock-enable bank.
// Increment constants assume a 50 MHz clk and a 32-bit accumulator.
package fracdiv_pkg;

  localparam int ACC_W_DEF       = 32;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int LOCK_W          = 8;

  typedef logic [LOCK_W-1:0] lock_cnt_t;

  // inc = round(f_out / 50 MHz * 2^32)
  localparam logic [31:0] INC_UART_1M8432 = 32'd158329674;
  localparam logic [31:0] INC_UART_115200 = 32'd9895605;
  localparam logic [31:0] INC_1MHZ        = 32'd85899346;
  localparam logic [31:0] INC_10MHZ       = 32'd858993459;

  function automatic logic ch_in_range(input logic [2:0] ch, input int num_ch);
    logic [3:0] lim;
    lim = 4'(num_ch);
    return ({1'b0, ch} < lim);
  endfunction

endpackage

// File: rtl/fracdiv_ch.sv
// One fractional-divider channel: increment register, phase accumulator and
// registered carry used as the clock-enable pulse.
module fracdiv_ch
  import fracdiv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             ce
);

  logic [ACC_W-1:0] inc_r;
  logic [ACC_W-1:0] acc_r;
  logic             ce_r;
  logic [ACC_W:0]   sum_s;

  // Next phase, one bit wider so the carry lands in the top bit
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, inc_r};
  end

  // Increment, phase and carry registers; phase is parked at zero unless running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_r <= {ACC_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
      ce_r  <= 1'b0;
    end else begin
      if (wr_en) begin
        inc_r <= wr_inc;
      end
      if (clr || !run) begin
        acc_r <= {ACC_W{1'b0}};
        ce_r  <= 1'b0;
      end else begin
        acc_r <= sum_s[ACC_W-1:0];
        ce_r  <= sum_s[ACC_W];
      end
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/fracdiv_ce_bank.sv
// Bank of NUM_CH fractional clock-enable generators sharing one lock counter,
// a single configuration write port and a common phase-realign input.
module fracdiv_ce_bank
  import fracdiv_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam lock_cnt_t LOCK_INIT = lock_cnt_t'(LOCK_CYCLES);

  lock_cnt_t         lock_cnt_r;
  lock_cnt_t         lock_cnt_nxt_s;
  logic              locked_r;
  logic              wr_acc_s;
  logic              clr_s;
  logic [NUM_CH-1:0] wr_en_s;

  // Write acceptance, shared phase clear and lock-counter next value.
  // An out-of-range channel is consumed by the handshake but touches nothing.
  always_comb begin
    wr_acc_s       = 1'b0;
    lock_cnt_nxt_s = lock_cnt_r;
    if (cfg_valid && locked_r && ch_in_range(cfg_ch, NUM_CH)) begin
      wr_acc_s = 1'b1;
    end else begin
      wr_acc_s = 1'b0;
    end
    clr_s = sync || wr_acc_s;
    if (wr_acc_s) begin
      lock_cnt_nxt_s = LOCK_INIT;
    end else if (lock_cnt_r != {LOCK_W{1'b0}}) begin
      lock_cnt_nxt_s = lock_cnt_r - lock_cnt_t'(1);
    end else begin
      lock_cnt_nxt_s = {LOCK_W{1'b0}};
    end
  end

  // Lock counter and registered lock flag (flag follows the next count so it
  // rises on the same edge the counter reaches zero)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt_r <= LOCK_INIT;
      locked_r   <= 1'b0;
    end else begin
      lock_cnt_r <= lock_cnt_nxt_s;
      locked_r   <= (lock_cnt_nxt_s == {LOCK_W{1'b0}});
    end
  end

  assign locked    = locked_r;
  assign cfg_ready = locked_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en_s[i] = wr_acc_s && (cfg_ch == 3'(i));

    fracdiv_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (locked_r),
      .clr    (clr_s),
      .wr_en  (wr_en_s[i]),
      .wr_inc (cfg_inc),
      .ce     (ce[i])
    );
  end

endmodule
